// File: rtl/sma_pkg.sv
// sma_pkg: shared parameters, derived widths and FSM state type for the
// multi-symbol simple-moving-average controller.
package sma_pkg;
   localparam int DATA_W  = 18;
   localparam int WINDOW  = 10;
   localparam int NUM_SYM = 4;

   localparam int SUM_W   = DATA_W + $clog2(WINDOW);
   localparam int CNT_W   = $clog2(WINDOW + 1);
   localparam int PTR_W   = $clog2(WINDOW);
   localparam int SYM_W   = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
   localparam int ADDR_W  = $clog2(NUM_SYM * WINDOW);
   localparam int ITER_W  = $clog2(SUM_W + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      UPD  = 3'd2,
      DIV  = 3'd3,
      OUT  = 3'd4
   } sma_state_t;
endpackage

// File: rtl/sma_div.sv
// sma_div: unsigned restoring divider, one quotient bit per clock.
//   i_start     load dividend/divisor and begin (ignored while running)
//   i_dividend  SUM_W-bit dividend
//   i_divisor   CNT_W-bit divisor, must be non-zero
//   o_done      high during the last iteration cycle (SUM_W cycles after start)
//   o_quotient  floor(dividend/divisor), valid the cycle after o_done and held
//               until the next start
module sma_div
   import sma_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [SUM_W-1:0] i_dividend,
   input  logic [CNT_W-1:0] i_divisor,
   output logic             o_done,
   output logic [SUM_W-1:0] o_quotient
);
   logic [SUM_W-1:0]  r_quo;
   logic [CNT_W-1:0]  r_rem;
   logic [CNT_W-1:0]  r_dvs;
   logic [ITER_W-1:0] r_iter;
   logic              r_busy;

   logic [CNT_W:0]    w_shift;
   logic [CNT_W:0]    w_trial;
   logic              w_ge;

   // remainder stays below the divisor, so one extra bit covers the trial
   assign w_shift = {r_rem, r_quo[SUM_W-1]};
   assign w_trial = w_shift - {1'b0, r_dvs};
   assign w_ge    = ~w_trial[CNT_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_quo  <= '0;
         r_rem  <= '0;
         r_dvs  <= '0;
         r_iter <= '0;
         r_busy <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_quo  <= i_dividend;
         r_rem  <= '0;
         r_dvs  <= i_divisor;
         r_iter <= ITER_W'(SUM_W);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_quo  <= {r_quo[SUM_W-2:0], w_ge};
         r_rem  <= w_ge ? w_trial[CNT_W-1:0] : w_shift[CNT_W-1:0];
         r_iter <= r_iter - 1'b1;
         if (r_iter == ITER_W'(1)) r_busy <= 1'b0;
      end
   end

   assign o_done     = r_busy && (r_iter == ITER_W'(1));
   assign o_quotient = r_quo;
endmodule

// File: rtl/sma_ctrl.sv
// sma_ctrl: sequences one shared moving-average datapath over NUM_SYM symbols.
//   in_*    sample input (valid/ready), symbol tag and price
//   clr_*   per-symbol history clear (level request, one-cycle ack)
//   out_*   average output (valid/ready) with symbol, floor average, full flag
//   busy    a sample is in flight
//
// state | meaning
// IDLE  | waiting; services clear requests, else accepts a sample
// RD    | synchronous read of the slot about to be overwritten
// UPD   | update sum/count/pointer, write sample, start divider
// DIV   | divider iterating (SUM_W cycles)
// OUT   | average presented until the consumer takes it
module sma_ctrl
   import sma_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SYM_W-1:0]  in_sym,
   input  logic [DATA_W-1:0] in_price,
   input  logic              clr_req,
   input  logic [SYM_W-1:0]  clr_sym,
   output logic              clr_ack,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SYM_W-1:0]  out_sym,
   output logic [DATA_W-1:0] out_avg,
   output logic              out_full,
   output logic              busy
);
   sma_state_t r_state, w_next;

   logic [SUM_W-1:0]  r_sum [NUM_SYM];
   logic [CNT_W-1:0]  r_cnt [NUM_SYM];
   logic [PTR_W-1:0]  r_ptr [NUM_SYM];
   logic [DATA_W-1:0] r_mem [NUM_SYM*WINDOW];

   logic [SYM_W-1:0]  r_sym;
   logic [DATA_W-1:0] r_price;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_full;
   logic              r_clr_ack;

   logic              w_accept;
   logic              w_clr_go;
   logic              w_div_start;
   logic              w_div_done;
   logic [SUM_W-1:0]  w_quo;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_old;
   logic [SUM_W-1:0]  w_sum_new;
   logic [CNT_W-1:0]  w_cnt_new;
   logic [PTR_W-1:0]  w_ptr_new;

   assign w_addr = ADDR_W'(r_sym) * ADDR_W'(WINDOW) + ADDR_W'(r_ptr[r_sym]);

   always_comb begin
      w_old     = (r_cnt[r_sym] == CNT_W'(WINDOW)) ? r_rd_data : '0;
      w_sum_new = r_sum[r_sym] - SUM_W'(w_old) + SUM_W'(r_price);
      w_cnt_new = (r_cnt[r_sym] == CNT_W'(WINDOW)) ? CNT_W'(WINDOW)
                                                   : r_cnt[r_sym] + 1'b1;
      w_ptr_new = (r_ptr[r_sym] == PTR_W'(WINDOW - 1)) ? '0
                                                       : r_ptr[r_sym] + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      w_clr_go    = 1'b0;
      w_div_start = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = !clr_req;
            // the request is still high during the ack cycle; do not re-clear
            if (clr_req) begin
               w_clr_go = !r_clr_ack;
            end else if (in_valid) begin
               w_accept = 1'b1;
               w_next   = RD;
            end
         end
         RD:  w_next = UPD;
         UPD: begin
            w_div_start = 1'b1;
            w_next      = DIV;
         end
         DIV: if (w_div_done) w_next = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SYM; i++) begin
            r_sum[i] <= '0;
            r_cnt[i] <= '0;
            r_ptr[i] <= '0;
         end
         r_sym     <= '0;
         r_price   <= '0;
         r_full    <= 1'b0;
         r_clr_ack <= 1'b0;
      end else begin
         r_clr_ack <= w_clr_go;
         if (w_clr_go) begin
            r_sum[clr_sym] <= '0;
            r_cnt[clr_sym] <= '0;
            r_ptr[clr_sym] <= '0;
         end
         if (w_accept) begin
            r_sym   <= in_sym;
            r_price <= in_price;
         end
         if (r_state == UPD) begin
            r_sum[r_sym] <= w_sum_new;
            r_cnt[r_sym] <= w_cnt_new;
            r_ptr[r_sym] <= w_ptr_new;
            r_full       <= (w_cnt_new == CNT_W'(WINDOW));
         end
      end
   end

   // sample memory is never reset; the per-symbol count gates every read
   always_ff @(posedge clk) begin
      if (r_state == RD)  r_rd_data     <= r_mem[w_addr];
      if (r_state == UPD) r_mem[w_addr] <= r_price;
   end

   sma_div u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_div_start),
      .i_dividend (w_sum_new),
      .i_divisor  (w_cnt_new),
      .o_done     (w_div_done),
      .o_quotient (w_quo)
   );

   assign out_avg  = w_quo[DATA_W-1:0];
   assign out_sym  = r_sym;
   assign out_full = r_full;
   assign clr_ack  = r_clr_ack;
   assign busy     = (r_state != IDLE);
endmodule

// File: tb/tb_sma_ctrl.sv
// tb_sma_ctrl: directed bench for sma_ctrl with a reference window model
// feeding an expected-result queue.
module tb_sma_ctrl;
   import sma_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [SYM_W-1:0]  in_sym;
   logic [DATA_W-1:0] in_price;
   logic              clr_req;
   logic [SYM_W-1:0]  clr_sym;
   logic              clr_ack;
   logic              out_valid;
   logic              out_ready;
   logic [SYM_W-1:0]  out_sym;
   logic [DATA_W-1:0] out_avg;
   logic              out_full;
   logic              busy;

   sma_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_price(in_price),
      .clr_req(clr_req), .clr_sym(clr_sym), .clr_ack(clr_ack),
      .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
      .out_avg(out_avg), .out_full(out_full), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int sym;
      int avg;
      bit full;
   } exp_t;

   exp_t sb[$];
   int   hist[NUM_SYM][$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_push(input int s, input int p);
      exp_t   e;
      longint sum;
      hist[s].push_back(p);
      if (hist[s].size() > WINDOW) void'(hist[s].pop_front());
      sum = 0;
      foreach (hist[s][i]) sum += hist[s][i];
      e.sym  = s;
      e.avg  = int'(sum / hist[s].size());
      e.full = (hist[s].size() == WINDOW);
      sb.push_back(e);
   endtask

   task automatic send(input int s, input int p);
      int n;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_sym   = SYM_W'(s);
      in_price = DATA_W'(p);
      @(posedge clk);
      #1 in_valid = 1'b0;
      model_push(s, p);
   endtask

   task automatic get_out(output int lat, output bit saw_ack);
      exp_t e;
      lat     = 0;
      saw_ack = 1'b0;
      while (lat < 300) begin
         @(negedge clk);
         lat++;
         if (clr_ack) saw_ack = 1'b1;
         if (out_valid) break;
      end
      if (!out_valid) begin
         chk("out_timeout", 0, 1);
         return;
      end
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      chk("out_sym", out_sym, e.sym);
      chk("out_avg", out_avg, e.avg);
      chk("out_full", out_full, e.full);
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int s, input int p);
      int lat;
      bit ack;
      send(s, p);
      get_out(lat, ack);
   endtask

   task automatic do_clear(input int s);
      int n;
      @(negedge clk);
      clr_req = 1'b1;
      clr_sym = SYM_W'(s);
      n = 0;
      while (!clr_ack && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("clr_ack_seen", clr_ack, 1);
      clr_req = 1'b0;
      hist[s].delete();
   endtask

   initial begin
      int lat;
      bit ack;
      int n;
      logic [DATA_W-1:0] hold_avg;
      logic [SYM_W-1:0]  hold_sym;
      exp_t e;

      rst_n = 1'b0; in_valid = 1'b0; in_sym = '0; in_price = '0;
      clr_req = 1'b0; clr_sym = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_avg", out_avg, 0);
      chk("rst_out_sym", out_sym, 0);
      chk("rst_out_full", out_full, 0);
      chk("rst_clr_ack", clr_ack, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);

      // single sample and latency
      send(0, 100);
      get_out(lat, ack);
      chk("latency", lat, 3 + SUM_W);

      // fill and slide on a fresh symbol 0
      do_clear(0);
      for (int i = 1; i <= 12; i++) sample(0, 10 * i);

      // truncation and extremes
      sample(1, 1);
      sample(1, 2);
      for (int i = 0; i < 10; i++) sample(1, 262143);
      for (int i = 0; i < 10; i++) sample(1, 0);

      // interleaving
      for (int i = 0; i < 5; i++) begin
         sample(2, 50);
         sample(3, 1000);
      end

      // backpressure
      out_ready = 1'b0;
      send(2, 60);
      n = 0;
      while (!out_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("bp_out_valid", out_valid, 1);
      e = sb.pop_front();
      chk("bp_out_avg", out_avg, e.avg);
      chk("bp_out_sym", out_sym, e.sym);
      hold_avg = out_avg;
      hold_sym = out_sym;
      in_valid = 1'b1; in_sym = 2'd3; in_price = 18'd9999;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_avg", out_avg, hold_avg);
         chk("bp_hold_sym", out_sym, hold_sym);
         chk("bp_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_released_valid", out_valid, 0);
      chk("bp_released_busy", busy, 0);

      // clear requested while symbol 0 is in the divider
      send(0, 130);
      repeat (5) @(negedge clk);
      chk("clr_during_div_busy", busy, 1);
      clr_req = 1'b1;
      clr_sym = 2'd0;
      get_out(lat, ack);
      chk("clr_ack_before_handshake", ack, 0);
      @(negedge clk);
      chk("clr_in_ready_blocked", in_ready, 0);
      n = 0;
      while (!clr_ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("clr_ack_after_handshake", clr_ack, 1);
      clr_req = 1'b0;
      hist[0].delete();
      sample(0, 7);

      // reset in the middle of a division
      send(1, 5);
      void'(sb.pop_back());
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int s = 0; s < NUM_SYM; s++) hist[s].delete();
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 1);
      sample(1, 40);
      sample(0, 8);
      sample(3, 1000);

      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
